seq_mult_unit: RTL and testbench

SEQ_MULT_UNIT -- requirements
Module: seq_mult_unit

---
 rtl/seq_mult_unit.sv | 94 +++++++++
 tb/tb_seq_mult_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_unit.sv
// Sequential shift-and-add multiplier with optional early termination.
// Signed operands are reduced to magnitudes on capture; the sign is reapplied in FIX.
module seq_mult_unit #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned     CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mplr;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic                 r_ready;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_mplr_shr;
  logic [2*WIDTH-1:0]   w_acc_add;
  logic                 w_last;

  // Negating -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign w_a_mag    = (sgn && a[WIDTH-1]) ? -a : a;
  assign w_b_mag    = (sgn && b[WIDTH-1]) ? -b : b;
  assign w_mplr_shr = r_mplr >> 1;
  assign w_acc_add  = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last     = (r_cnt == LastCnt) || (EARLY_EXIT && (w_mplr_shr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplr    <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplr  <= w_b_mag;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_ready <= 1'b0;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          r_acc   <= w_acc_add;
          r_mcand <= r_mcand << 1;
          r_mplr  <= w_mplr_shr;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) r_state <= StFix;
        end
        StFix: begin
          // A zero accumulator is never negated, so no negative zero can appear.
          r_product <= (r_neg && (r_acc != '0)) ? -r_acc : r_acc;
          r_done    <= 1'b1;
          r_ready   <= 1'b1;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ready   = r_ready;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Bench for seq_mult_unit: two instances (EARLY_EXIT 0 and 1) share stimulus and are
// checked every cycle against an arithmetic model, plus hand-computed literal expectations.
module tb_seq_mult_unit;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        sgn   = 1'b0;
  logic [7:0]  a     = '0;
  logic [7:0]  b     = '0;
  logic        ready0, done0, ready1, done1;
  logic [15:0] prod0, prod1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seq_mult_unit #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn), .a(a), .b(b),
    .ready(ready0), .done(done0), .product(prod0)
  );

  seq_mult_unit #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn), .a(a), .b(b),
    .ready(ready1), .done(done1), .product(prod1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [15:0] ref_mul(input logic s, input logic [7:0] x, input logic [7:0] y);
    int xv, yv;
    xv = s ? int'($signed(x)) : int'(x);
    yv = s ? int'($signed(y)) : int'(y);
    return 16'(xv * yv);
  endfunction

  // Edges from accepting start to done: WIDTH+1, or (significant multiplier bits, min 1)+1.
  function automatic int model_lat(input int ee, input logic s, input logic [7:0] y);
    int mag, n;
    if (ee == 0) return 9;
    mag = s ? int'($signed(y)) : int'(y);
    if (mag < 0) mag = -mag;
    n = 0;
    while (mag > 0) begin
      n++;
      mag = mag >> 1;
    end
    if (n == 0) n = 1;
    return n + 1;
  endfunction

  logic        m_ready [2];
  logic        m_done  [2];
  logic [15:0] m_prod  [2];
  logic [15:0] m_pend  [2];
  int          m_left  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ready[i] <= 1'b1;
        m_done[i]  <= 1'b0;
        m_prod[i]  <= '0;
        m_pend[i]  <= '0;
        m_left[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        if (m_left[i] != 0) begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_prod[i]  <= m_pend[i];
            m_done[i]  <= 1'b1;
            m_ready[i] <= 1'b1;
          end
        end else if (start && m_ready[i]) begin
          m_ready[i] <= 1'b0;
          m_pend[i]  <= ref_mul(sgn, a, b);
          m_left[i]  <= model_lat(i, sgn, b);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ready0", longint'(ready0), longint'(m_ready[0]));
    chk("done0",  longint'(done0),  longint'(m_done[0]));
    chk("prod0",  longint'(prod0),  longint'(m_prod[0]));
    chk("ready1", longint'(ready1), longint'(m_ready[1]));
    chk("done1",  longint'(done1),  longint'(m_done[1]));
    chk("prod1",  longint'(prod1),  longint'(m_prod[1]));
  end

  // busy_at / rst_at: offsets from the start edge for a stray start or a reset (0 = none).
  task automatic run_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                        input int busy_at, input int rst_at,
                        output int k, output int d0, output int d1,
                        output int n0, output int n1);
    @(negedge clk);
    start = 1'b1; sgn = s; a = x; b = y;
    k  = cyc + 1;
    d0 = -1; d1 = -1; n0 = 0; n1 = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done0) begin n0++; d0 = cyc; end
      if (done1) begin n1++; d1 = cyc; end
      if (busy_at != 0 && cyc == k + busy_at - 1) begin
        start = 1'b1; a = 8'd2; b = 8'd2;
      end
      if (rst_at != 0 && cyc == k + rst_at - 1) begin
        #2 rst_n = 1'b0;
      end
      if (rst_at != 0 && cyc == k + rst_at + 1) begin
        #2 rst_n = 1'b1;
      end
    end
  endtask

  task automatic lit(input string name, input logic [15:0] exp);
    chk({name, "_dut0"},  longint'(prod0),     longint'(exp));
    chk({name, "_dut1"},  longint'(prod1),     longint'(exp));
    chk({name, "_model"}, longint'(m_prod[0]), longint'(exp));
  endtask

  initial begin
    int k, d0, d1, n0, n1;
    bit seen;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", longint'(ready0), 1);
    chk("rst_done",  longint'(done0),  0);
    chk("rst_prod",  longint'(prod0),  0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 8'd13, 8'd11, 3, 0, k, d0, d1, n0, n1);
    lit("u13x11", 16'h008F);
    chk("u13x11_done_at", longint'(d0 - k), 9);
    chk("u13x11_ee_done_at", longint'(d1 - k), 5);
    chk("u13x11_pulses0", longint'(n0), 1);
    chk("u13x11_pulses1", longint'(n1), 1);

    run_op(1'b0, 8'hFF, 8'hFF, 0, 0, k, d0, d1, n0, n1);
    lit("u255x255", 16'hFE01);

    run_op(1'b1, 8'h80, 8'h80, 0, 0, k, d0, d1, n0, n1);
    lit("s_m128sq", 16'h4000);

    run_op(1'b1, 8'hFD, 8'h05, 0, 0, k, d0, d1, n0, n1);
    lit("s_m3x5", 16'hFFF1);

    run_op(1'b1, 8'h00, 8'h80, 0, 0, k, d0, d1, n0, n1);
    lit("s_0xm128", 16'h0000);

    run_op(1'b0, 8'd200, 8'd1, 0, 0, k, d0, d1, n0, n1);
    lit("u200x1", 16'd200);
    chk("u200x1_ee_done_at", longint'(d1 - k), 2);
    chk("u200x1_done_at", longint'(d0 - k), 9);

    run_op(1'b0, 8'd3, 8'h80, 0, 0, k, d0, d1, n0, n1);
    lit("u3x128", 16'd384);
    chk("u3x128_ee_done_at", longint'(d1 - k), 9);

    // Start issued in the very cycle dut0 shows done.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 8'd5; b = 8'd5;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    chk("b2b_first_done", longint'(seen), 1);
    chk("b2b_first_prod", longint'(prod0), 25);
    start = 1'b1; a = 8'd7; b = 8'd9;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_prod_held", longint'(prod0), 25);
    repeat (14) @(negedge clk);
    lit("b2b_7x9", 16'd63);

    run_op(1'b0, 8'd50, 8'd100, 0, 4, k, d0, d1, n0, n1);
    lit("abort", 16'h0000);
    chk("abort_pulses0", longint'(n0), 0);
    chk("abort_pulses1", longint'(n1), 0);
    chk("abort_ready", longint'(ready0), 1);

    run_op(1'b0, 8'd6, 8'd7, 0, 0, k, d0, d1, n0, n1);
    lit("u6x7", 16'd42);
    chk("u6x7_done_at", longint'(d0 - k), 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
